// File: rtl/cfg_arb_pkg.sv
// Shared constants and FSM state type for the configuration register bank
// and the management-access arbiter in front of it.
package cfg_arb_pkg;

    localparam int CFG_ADDR_W = 5;
    localparam int CFG_DATA_W = 16;
    localparam logic [CFG_ADDR_W-1:0] CFG_RO_BASE = 5'd24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/cfg_access_arbiter_if.sv
// Requester handshake plus config-bank port bundle for cfg_access_arbiter.
interface cfg_access_arbiter_if
    import cfg_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = CFG_ADDR_W,
    parameter int DATA_W  = CFG_DATA_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic [ADDR_W-1:0]         config_addr;
    logic [DATA_W-1:0]         config_data;
    logic                      config_write;
    logic                      config_read;
    logic [DATA_W-1:0]         config_rd_data;
    logic                      busy;

    // The arbiter side; the requesters and the register bank together form the master side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, config_rd_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               config_addr, config_data, config_write, config_read, busy
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, config_rd_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               config_addr, config_data, config_write, config_read, busy
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first active request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]                             req_i,
    input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]                             grant_o,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_idx_o,
    output logic                                           any_req_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] idx;

    // Scanning from the farthest position back to ptr lets the nearest active request win.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        idx         = '0;
        any_req_o   = |req_i;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (req_i[idx]) begin
                grant_idx_o = idx;
            end
        end
        if (any_req_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/cfg_access_arbiter.sv
// Round-robin arbiter/sequencer sharing the single-port config register bank
// between management requesters; one transaction in flight at a time.
module cfg_access_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int                NUM_REQ = 3,
    parameter int                ADDR_W  = CFG_ADDR_W,
    parameter int                DATA_W  = CFG_DATA_W,
    parameter logic [ADDR_W-1:0] RO_BASE = CFG_RO_BASE
) (
    input  logic                 clk,
    input  logic                 rst,
    cfg_access_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic               sel_write;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i       (bus.req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (pick_onehot),
        .grant_idx_o (pick_idx),
        .any_req_o   (pick_any)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_write = bus.req_write[i];
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Bank address/data follow the latch so they hold their last value between transactions.
    assign bus.config_addr = addr_q;
    assign bus.config_data = wdata_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        bus.req_ready    = '0;
        bus.rsp_valid    = '0;
        bus.rsp_rdata    = '0;
        bus.rsp_err      = 1'b0;
        bus.config_write = 1'b0;
        bus.config_read  = 1'b0;
        bus.busy         = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                // No accept while reset is high: the handshake would be lost on the reset edge.
                if (pick_any && !rst) begin
                    bus.req_ready = pick_onehot;
                    gnt_d   = pick_idx;
                    write_d = sel_write;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = 1'b0;
                    ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!write_q) begin
                    bus.config_read = 1'b1;
                end else if (addr_q < RO_BASE) begin
                    bus.config_write = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid[gnt_q] = 1'b1;
                if (!write_q) begin
                    bus.rsp_rdata = bus.config_rd_data;
                end
                bus.rsp_err = err_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_cfg_access_arbiter.sv
// Self-checking bench for cfg_access_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_cfg_access_arbiter;

    localparam int N = 3;

    logic clk;
    logic rst;
    logic [N-1:0] valid;
    logic [N-1:0] wr;
    logic [4:0]   addrA [N];
    logic [15:0]  dataA [N];
    logic [15:0]  rdData;
    logic [15:0]  bank [32];
    logic [15:0]  refMem [32];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chkEn = 0;
    logic [N-1:0] accSeen = '0;

    cfg_access_arbiter_if #(.NUM_REQ(N), .ADDR_W(5), .DATA_W(16)) bus ();

    cfg_access_arbiter #(
        .NUM_REQ(N), .ADDR_W(5), .DATA_W(16), .RO_BASE(5'd24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.req_valid      = valid;
    assign bus.req_write      = wr;
    assign bus.req_addr       = {addrA[2], addrA[1], addrA[0]};
    assign bus.req_wdata      = {dataA[2], dataA[1], dataA[0]};
    assign bus.config_rd_data = rdData;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register bank model: strobes captured mid-cycle, applied on the rising edge.
    logic       bkRd = 1'b0;
    logic       bkWr = 1'b0;
    logic [4:0] bkA  = '0;
    logic [15:0] bkD = '0;
    always @(negedge clk) begin
        bkRd = (bus.config_read === 1'b1);
        bkWr = (bus.config_write === 1'b1);
        bkA  = bus.config_addr;
        bkD  = bus.config_data;
        accSeen = bus.req_ready;
    end
    always @(posedge clk) begin
        if (bkWr) bank[bkA] <= bkD;
        if (bkRd) rdData <= bank[bkA];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a granted transaction strobes one cycle later
    // and responds two cycles later; nothing else can be granted meanwhile.
    int          mPtr   = 0;
    bit          mBusy  = 0;
    int          mStart = 0;
    int          mG     = 0;
    bit          mWr    = 0;
    logic [4:0]  mAddr  = '0;
    logic [15:0] mData  = '0;
    int          now    = 0;

    always @(negedge clk) begin : cmp
        logic [N-1:0] vv, expReady, expRsp;
        logic expRd, expWr, expErr, found;
        logic [15:0] expRdata;
        int age, g;
        if (chkEn) begin
            vv = bus.req_valid;
            age = mBusy ? (now - mStart) : 0;
            expReady = '0; expRsp = '0; expRd = 0; expWr = 0; expErr = 0;
            expRdata = '0; found = 0; g = 0;
            if (!mBusy && !rst) begin
                for (int k = 0; k < N; k++) begin
                    if (!found && vv[2'((mPtr + k) % N)]) begin
                        found = 1;
                        g = (mPtr + k) % N;
                    end
                end
                if (found) expReady = 3'(1 << g);
            end
            if (age == 1) begin
                if (!mWr) expRd = 1;
                else if (mAddr < 5'd24) expWr = 1;
            end
            if (age == 2) begin
                expRsp   = 3'(1 << mG);
                expRdata = mWr ? 16'h0 : refMem[mAddr];
                expErr   = mWr && (mAddr >= 5'd24);
            end
            checkOutput("m_busy",      32'(bus.busy),         32'(mBusy));
            checkOutput("m_ready",     32'(bus.req_ready),    32'(expReady));
            checkOutput("m_cfg_read",  32'(bus.config_read),  32'(expRd));
            checkOutput("m_cfg_write", 32'(bus.config_write), 32'(expWr));
            checkOutput("m_rsp_valid", 32'(bus.rsp_valid),    32'(expRsp));
            checkOutput("m_rsp_rdata", 32'(bus.rsp_rdata),    32'(expRdata));
            if (age == 1 || age == 2)
                checkOutput("m_cfg_addr", 32'(bus.config_addr), 32'(mAddr));
            if (expWr)
                checkOutput("m_cfg_data", 32'(bus.config_data), 32'(mData));
            if (age == 2)
                checkOutput("m_rsp_err", 32'(bus.rsp_err), 32'(expErr));

            if (expWr) refMem[mAddr] = mData;
            if (rst) begin
                mBusy = 0;
                mPtr  = 0;
            end else if (!mBusy && found) begin
                mBusy  = 1;
                mStart = now;
                mG     = g;
                mWr    = wr[2'(g)];
                mAddr  = addrA[2'(g)];
                mData  = dataA[2'(g)];
                mPtr   = (g + 1) % N;
            end else if (age == 2) begin
                mBusy = 0;
            end
            now++;
        end
    end

    // Raise one request and hold it until accepted; returns in the strobe cycle.
    task automatic applyStimulus(input int r, input bit w, input int a, input int d, output int waited);
        @(posedge clk); #1;
        valid = valid | 3'(1 << r);
        wr[2'(r)]    = w;
        addrA[2'(r)] = 5'(a);
        dataA[2'(r)] = 16'(d);
        waited = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.req_ready == 3'(1 << r)) begin
                waited = t;
                break;
            end
        end
        if (waited < 0) checkOutput("grant_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
        valid = valid & ~3'(1 << r);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int waited, cnt, cnt2, ng;
        int gIdx [9];
        int gCyc [9];
        logic [15:0] v;

        rst = 1'b1;
        valid = '0;
        wr = '0;
        for (int i = 0; i < N; i++) begin
            addrA[i] = '0;
            dataA[i] = '0;
        end
        for (int i = 0; i < 32; i++) begin
            v = (i == 3) ? 16'hBEEF : (i == 25) ? 16'h5A5A : 16'($urandom);
            bank[i] <= v;
            refMem[i] = v;
        end
        @(posedge clk); #1;
        chkEn = 1;
        @(negedge clk);
        checkOutput("reset_busy",      32'(bus.busy),        32'(0));
        checkOutput("reset_ready",     32'(bus.req_ready),   32'(0));
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid),   32'(0));
        checkOutput("reset_cfg_addr",  32'(bus.config_addr), 32'(0));
        checkOutput("reset_rdata",     32'(bus.rsp_rdata),   32'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] single read");
        applyStimulus(1, 0, 3, 0, waited);
        checkOutput("rd_ready_c0", 32'(waited), 32'(0));
        @(negedge clk);
        checkOutput("rd_strobe_c1", 32'(bus.config_read), 32'(1));
        checkOutput("rd_addr_c1",   32'(bus.config_addr), 32'(3));
        @(negedge clk);
        checkOutput("rd_rsp_c2",   32'(bus.rsp_valid), 32'(3'b010));
        checkOutput("rd_data_c2",  32'(bus.rsp_rdata), 32'(16'hBEEF));
        checkOutput("rd_err_c2",   32'(bus.rsp_err),   32'(0));

        $display("[TB] write then read-back");
        applyStimulus(0, 1, 7, 16'h1234, waited);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.config_write === 1'b1) cnt++;
        end
        checkOutput("wr_strobe_count", 32'(cnt), 32'(1));
        applyStimulus(0, 0, 7, 0, waited);
        @(negedge clk);
        @(negedge clk);
        checkOutput("wr_readback", 32'(bus.rsp_rdata), 32'(16'h1234));

        $display("[TB] round-robin");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wr = '0;
        for (int i = 0; i < N; i++) addrA[i] = 5'(i + 1);
        valid = 3'b111;
        ng = 0;
        for (int t = 0; t < 60 && ng < 9; t++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (bus.req_ready == 3'(1 << k)) begin
                    gIdx[ng] = k;
                    gCyc[ng] = cyc;
                    ng++;
                end
            end
        end
        @(posedge clk); #1;
        valid = '0;
        checkOutput("rr_grant_count", 32'(ng), 32'(9));
        for (int n = 0; n < ng; n++) begin
            checkOutput("rr_order", 32'(gIdx[n]), 32'(n % 3));
            if (n > 0) checkOutput("rr_spacing", 32'(gCyc[n] - gCyc[n-1]), 32'(3));
        end
        idleCycles(4);

        $display("[TB] read-only window");
        applyStimulus(2, 1, 25, 16'hFFFF, waited);
        cnt = 0;
        @(negedge clk);
        if (bus.config_write === 1'b1) cnt++;
        @(negedge clk);
        if (bus.config_write === 1'b1) cnt++;
        checkOutput("ro_no_write", 32'(cnt), 32'(0));
        checkOutput("ro_rsp",      32'(bus.rsp_valid), 32'(3'b100));
        checkOutput("ro_err",      32'(bus.rsp_err),   32'(1));
        applyStimulus(2, 0, 25, 0, waited);
        @(negedge clk);
        @(negedge clk);
        checkOutput("ro_unchanged", 32'(bus.rsp_rdata), 32'(16'h5A5A));

        $display("[TB] reset mid-transaction");
        applyStimulus(0, 1, 10, 16'hCAFE, waited);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 32'(bus.busy),      32'(0));
        checkOutput("rst_rsp",  32'(bus.rsp_valid), 32'(0));
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 3'b000) cnt++;
        end
        checkOutput("rst_no_late_rsp", 32'(cnt), 32'(0));
        @(posedge clk); #1;
        wr = '0;
        valid = 3'b111;
        @(negedge clk);
        checkOutput("rst_ptr_zero", 32'(bus.req_ready), 32'(3'b001));
        @(posedge clk); #1;
        valid = '0;
        idleCycles(4);

        $display("[TB] withdrawal during contention");
        applyStimulus(0, 0, 4, 0, waited);
        valid[1] = 1'b1;
        wr[1]    = 1'b1;
        addrA[1] = 5'd5;
        @(posedge clk); #1;
        valid[1] = 1'b0;
        cnt = 0;
        cnt2 = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.req_ready[1] === 1'b1 || bus.rsp_valid[1] === 1'b1) cnt++;
            if (bus.rsp_valid[0] === 1'b1) cnt2++;
        end
        checkOutput("wd_no_grant1", 32'(cnt),  32'(0));
        checkOutput("wd_rsp0",      32'(cnt2), 32'(1));

        $display("[TB] randomized traffic");
        valid = '0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < N; i++) begin
                if (valid[i] && !accSeen[i]) begin
                    if ($urandom_range(0, 19) == 0) valid[i] = 1'b0;
                end else begin
                    if (valid[i] && $urandom_range(0, 1) == 0) valid[i] = 1'b0;
                    else if (valid[i] || $urandom_range(0, 9) < 3) begin
                        valid[i] = 1'b1;
                        wr[i]    = 1'($urandom_range(0, 1));
                        addrA[i] = 5'($urandom_range(0, 31));
                        dataA[i] = 16'($urandom);
                    end
                end
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        valid = '0;
        idleCycles(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
